// File: rtl/rom_loader_ctrl_pkg.sv
// rtl/rom_loader_ctrl_pkg.sv - shared constants for the Hack run controller
package rom_loader_ctrl_pkg;

    localparam int HACK_ROM_ADDR_W  = 15;
    localparam int HALT_WIN_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

endpackage

// File: rtl/rom_loader_ctrl_if.sv
// rtl/rom_loader_ctrl_if.sv - program word stream from the host front end
interface rom_loader_ctrl_if;

    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/rom_loader_ctrl_halt_detector.sv
// rtl/rom_loader_ctrl_halt_detector.sv - flags the Hack halt loop (pc repeating with period 1 or 2)
module rom_loader_ctrl_halt_detector #(
    parameter int HALT_WIN = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] cpu_pc,
    output logic        halt_hit
);

    logic [15:0] pc_d1_q, pc_d2_q;
    logic [1:0]  hist_q;
    logic [3:0]  match_cnt_q;
    logic        match;

    // Comparing against pc two cycles back catches both 1- and 2-instruction loops.
    assign match    = (hist_q == 2'd2) && (cpu_pc == pc_d2_q);
    assign halt_hit = enable && match && (({1'b0, match_cnt_q} + 5'd1) >= 5'(HALT_WIN));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            pc_d1_q     <= '0;
            pc_d2_q     <= '0;
            hist_q      <= '0;
            match_cnt_q <= '0;
        end else if (enable) begin
            pc_d1_q <= cpu_pc;
            pc_d2_q <= pc_d1_q;
            if (hist_q != 2'd2) begin
                hist_q <= hist_q + 2'd1;
            end
            if (!match) begin
                match_cnt_q <= '0;
            end else if (match_cnt_q != 4'hF) begin
                match_cnt_q <= match_cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/rom_loader_ctrl.sv
// rtl/rom_loader_ctrl.sv - loads Hack ROM from a stream under CPU reset, then runs and watches for halt
module rom_loader_ctrl
    import rom_loader_ctrl_pkg::*;
#(
    parameter int ADDR_W   = HACK_ROM_ADDR_W,
    parameter int LEN_W    = 16,
    parameter int HALT_WIN = HALT_WIN_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_load,
    input  logic [LEN_W-1:0]    load_len,
    rom_loader_ctrl_if.slave    s,
    output logic                rom_we,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic [15:0]         rom_wdata,
    output logic                cpu_reset,
    input  logic [15:0]         cpu_pc,
    output logic                loading,
    output logic                running,
    output logic                halted,
    output logic [31:0]         cycle_count
);

    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(1) << ADDR_W;
    localparam logic [ADDR_W:0]   WCNT_ONE = (ADDR_W + 1)'(1);

    logic [1:0]      state_q, state_d;
    logic [ADDR_W:0] len_q, len_d, len_clamp;
    logic [ADDR_W:0] wcnt_q, wcnt_d;
    logic [31:0]     cyc_q, cyc_d;
    logic            cpu_reset_q, cpu_reset_d;
    logic            xfer, halt_hit;

    assign len_clamp = (load_len > LEN_MAX) ? LEN_MAX[ADDR_W:0] : load_len[ADDR_W:0];

    // Gated by reset so a word presented during a synchronous reset is never written.
    assign s.s_ready = (state_q == ST_LOAD) && !reset;
    assign xfer      = s.s_valid && s.s_ready;
    assign rom_we    = xfer;
    assign rom_addr  = wcnt_q[ADDR_W-1:0];
    assign rom_wdata = xfer ? s.s_data : 16'h0000;

    assign loading     = (state_q == ST_LOAD);
    assign running     = (state_q == ST_RUN);
    assign halted      = (state_q == ST_HALTED);
    assign cpu_reset   = cpu_reset_q;
    assign cycle_count = cyc_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        cyc_d   = cyc_q;
        if (start_load) begin
            len_d   = len_clamp;
            wcnt_d  = '0;
            cyc_d   = '0;
            state_d = (len_clamp == '0) ? ST_RUN : ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (xfer) begin
                        wcnt_d = wcnt_q + WCNT_ONE;
                        if ((wcnt_q + WCNT_ONE) == len_q) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (cyc_q != 32'hFFFF_FFFF) begin
                        cyc_d = cyc_q + 32'd1;
                    end
                    if (halt_hit) begin
                        state_d = ST_HALTED;
                    end
                end
                default: ;
            endcase
        end
        cpu_reset_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wcnt_q      <= '0;
            cyc_q       <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            cyc_q       <= cyc_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    // History is wiped outside RUN and on any restart, so every entry to RUN starts clean.
    rom_loader_ctrl_halt_detector #(
        .HALT_WIN (HALT_WIN)
    ) u_halt_detector (
        .clock    (clock),
        .reset    (reset),
        .clear    (start_load || (state_q != ST_RUN)),
        .enable   ((state_q == ST_RUN) && !start_load),
        .cpu_pc   (cpu_pc),
        .halt_hit (halt_hit)
    );

endmodule

// File: tb/tb_rom_loader_ctrl.sv
// tb/tb_rom_loader_ctrl.sv - directed self-checking bench for rom_loader_ctrl
module tb_rom_loader_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_load;
    logic [15:0] load_len;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_reset;
    logic [15:0] cpu_pc;
    logic        loading, running, halted;
    logic [31:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

    rom_loader_ctrl_if s_if ();

    rom_loader_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start_load  (start_load),
        .load_len    (load_len),
        .s           (s_if),
        .rom_we      (rom_we),
        .rom_addr    (rom_addr),
        .rom_wdata   (rom_wdata),
        .cpu_reset   (cpu_reset),
        .cpu_pc      (cpu_pc),
        .loading     (loading),
        .running     (running),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, " s_ready"}, 32'(s_if.s_ready), 32'd0);
        check({tag, " rom_we"}, 32'(rom_we), 32'd0);
        check({tag, " rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, " rom_wdata"}, 32'(rom_wdata), 32'd0);
        check({tag, " cycle_count"}, cycle_count, 32'd0);
        check({tag, " flags"}, {29'd0, loading, running, halted}, 32'd0);
    endtask

    logic [15:0] prog [3];
    logic        vpat [6];
    logic [15:0] pcs  [11];
    int          nwr;

    initial begin
        prog = '{16'h0002, 16'hEC10, 16'hE308};
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        pcs  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd4, 16'd3, 16'd4, 16'd3, 16'd4};

        reset = 1'b1; start_load = 1'b0; load_len = '0; cpu_pc = '0;
        s_if.s_valid = 1'b0; s_if.s_data = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check_reset_vals("rst");

        // Continuous load of three words
        start_load = 1'b1; load_len = 16'd3;
        tick();
        start_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_if.s_valid = 1'b1; s_if.s_data = prog[i];
            #1;
            check("ld1 we", 32'(rom_we), 32'd1);
            check("ld1 addr", 32'(rom_addr), 32'(i));
            check("ld1 data", 32'(rom_wdata), 32'(prog[i]));
            check("ld1 cpu_reset", 32'(cpu_reset), 32'd1);
            check("ld1 loading", 32'(loading), 32'd1);
            tick();
        end
        #1;
        check("ld1 s_ready drop", 32'(s_if.s_ready), 32'd0);
        check("ld1 we after", 32'(rom_we), 32'd0);
        check("ld1 running", 32'(running), 32'd1);
        check("ld1 cpu_reset run", 32'(cpu_reset), 32'd0);
        check("ld1 cyc0", cycle_count, 32'd0);
        s_if.s_valid = 1'b0;
        tick();
        check("ld1 cyc1", cycle_count, 32'd1);

        // Abort from RUN into a bubbly reload
        start_load = 1'b1; load_len = 16'd3;
        tick();
        start_load = 1'b0;
        nwr = 0;
        for (int i = 0; i < 6; i++) begin
            s_if.s_valid = vpat[i]; s_if.s_data = 16'(16'h1000 + i);
            #1;
            check("bub we", 32'(rom_we), 32'(vpat[i]));
            check("bub addr", 32'(rom_addr), 32'(nwr));
            if (vpat[i]) nwr++;
            tick();
        end
        s_if.s_valid = 1'b0;
        check("bub writes", 32'(nwr), 32'd3);

        // Halt loop 3,4,3,4: 4th match at RUN cycle 8, HALTED from cycle 9
        for (int k = 0; k < 11; k++) begin
            cpu_pc = pcs[k];
            #1;
            check("halt flag", 32'(halted), (k >= 9) ? 32'd1 : 32'd0);
            check("halt cyc", cycle_count, (k >= 9) ? 32'd9 : 32'(k));
            check("halt cpu_reset", 32'(cpu_reset), 32'd0);
            tick();
        end

        // Zero-length start from IDLE
        reset = 1'b1; tick(); reset = 1'b0;
        start_load = 1'b1; load_len = 16'd0; s_if.s_valid = 1'b1;
        #1;
        check("len0 ready idle", 32'(s_if.s_ready), 32'd0);
        check("len0 we idle", 32'(rom_we), 32'd0);
        tick();
        start_load = 1'b0;
        #1;
        check("len0 running", 32'(running), 32'd1);
        check("len0 cpu_reset", 32'(cpu_reset), 32'd0);
        check("len0 ready", 32'(s_if.s_ready), 32'd0);
        check("len0 we", 32'(rom_we), 32'd0);
        s_if.s_valid = 1'b0;

        // Run 20 cycles with advancing pc, then abort with len 5
        for (int k = 0; k < 20; k++) begin
            cpu_pc = 16'(16'h0100 + k);
            tick();
        end
        check("abort cyc20", cycle_count, 32'd20);
        start_load = 1'b1; load_len = 16'd5;
        tick();
        start_load = 1'b0;
        #1;
        check("abort loading", 32'(loading), 32'd1);
        check("abort cpu_reset", 32'(cpu_reset), 32'd1);
        check("abort cyc", cycle_count, 32'd0);
        check("abort addr", 32'(rom_addr), 32'd0);
        for (int i = 0; i < 2; i++) begin
            s_if.s_valid = 1'b1; s_if.s_data = 16'(16'hA000 + i);
            #1;
            check("abort wr addr", 32'(rom_addr), 32'(i));
            tick();
        end

        // Restart with len 4, reset after two words
        start_load = 1'b1; load_len = 16'd4;
        tick();
        start_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_if.s_valid = 1'b1; s_if.s_data = 16'(16'hB000 + i);
            #1;
            check("rl addr", 32'(rom_addr), 32'(i));
            tick();
        end
        reset = 1'b1; s_if.s_data = 16'hB002;
        #1;
        check("rl reset we", 32'(rom_we), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_reset_vals("rl post");
        start_load = 1'b1; load_len = 16'd2;
        tick();
        start_load = 1'b0;
        #1;
        check("rl reload we", 32'(rom_we), 32'd1);
        check("rl reload addr", 32'(rom_addr), 32'd0);
        s_if.s_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
